// File: rtl/exc_commit_seq.sv
// rtl/exc_commit_seq.sv - commit-stage precise exception / ERET sequencer
module exc_commit_seq #(
  parameter logic [31:0] EXC_BASE    = 32'hBFC00380,
  parameter logic [31:0] REFILL_BASE = 32'hBFC00200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s0_valid,
  input  logic        s1_valid,
  input  logic        s0_exc,
  input  logic        s1_exc,
  input  logic [4:0]  s0_code,
  input  logic [4:0]  s1_code,
  input  logic [31:0] s0_pc,
  input  logic [31:0] s1_pc,
  input  logic        s0_bd,
  input  logic        s1_bd,
  input  logic        s0_badva_v,
  input  logic        s1_badva_v,
  input  logic [31:0] s0_badva,
  input  logic [31:0] s1_badva,
  input  logic        s0_refill,
  input  logic        s1_refill,
  input  logic        s0_eret,
  input  logic        s1_eret,
  input  logic        int_req,
  input  logic        status_exl,
  input  logic [31:0] cp0_epc,
  input  logic        mem_busy,
  input  logic        fetch_ready,
  output logic        commit_stall,
  output logic        s1_kill,
  output logic        flush,
  output logic        cp0_exc_we,
  output logic [31:0] cp0_epc_wd,
  output logic [4:0]  cp0_code_wd,
  output logic        cp0_bd_wd,
  output logic        cp0_badva_we,
  output logic [31:0] cp0_badva_wd,
  output logic        cp0_clr_exl,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, DRAIN, WRITE, REDIR} state_t;

  state_t      state, state_nx;
  logic [31:0] r_pc, r_badva, r_tgt;
  logic [4:0]  r_code;
  logic        r_bd, r_badva_v, r_refill, r_eret, r_exl;

  logic        win0, win1, int1, ev, sel_int, sel_exc;
  logic [31:0] sel_pc, sel_badva;
  logic [4:0]  sel_code;
  logic        sel_bd, sel_badva_v, sel_refill, sel_eret;

  // An interrupt rides on slot0 when present, else on a lone slot1, and forces code 0.
  always_comb begin
    win0    = s0_valid & (s0_exc | s0_eret | int_req);
    int1    = int_req & ~s0_valid;
    win1    = ~win0 & s1_valid & (s1_exc | s1_eret | int1);
    ev      = resetn & (state == IDLE) & (win0 | win1);
    sel_int = win0 ? int_req : int1;
    sel_exc = win0 ? s0_exc : s1_exc;
    sel_pc      = win0 ? s0_pc      : s1_pc;
    sel_bd      = win0 ? s0_bd      : s1_bd;
    sel_badva   = win0 ? s0_badva   : s1_badva;
    sel_code    = sel_int ? 5'd0 : (win0 ? s0_code : s1_code);
    sel_badva_v = ~sel_int & (win0 ? s0_badva_v : s1_badva_v);
    sel_refill  = ~sel_int & (win0 ? s0_refill  : s1_refill);
    sel_eret    = ~sel_int & ~sel_exc & (win0 ? s0_eret : s1_eret);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      r_pc      <= '0;
      r_badva   <= '0;
      r_tgt     <= '0;
      r_code    <= '0;
      r_bd      <= 1'b0;
      r_badva_v <= 1'b0;
      r_refill  <= 1'b0;
      r_eret    <= 1'b0;
      r_exl     <= 1'b0;
    end else begin
      state <= state_nx;
      if (ev) begin
        r_pc      <= sel_pc;
        r_bd      <= sel_bd;
        r_code    <= sel_code;
        r_badva   <= sel_badva;
        r_badva_v <= sel_badva_v;
        r_refill  <= sel_refill;
        r_eret    <= sel_eret;
        r_exl     <= status_exl;
      end
      // EPC is sampled in the WRITE cycle so an ERET sees any just-completed mtc0.
      if (state == WRITE)
        r_tgt <= r_eret ? cp0_epc : ((r_refill && !r_exl) ? REFILL_BASE : EXC_BASE);
    end
  end

  always_comb begin
    state_nx       = state;
    commit_stall   = 1'b0;
    s1_kill        = 1'b0;
    flush          = 1'b0;
    cp0_exc_we     = 1'b0;
    cp0_epc_wd     = '0;
    cp0_code_wd    = '0;
    cp0_bd_wd      = 1'b0;
    cp0_badva_we   = 1'b0;
    cp0_badva_wd   = '0;
    cp0_clr_exl    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (ev) begin
          commit_stall = 1'b1;
          flush        = 1'b1;
          s1_kill      = 1'b1;
          state_nx     = mem_busy ? DRAIN : WRITE;
        end
      end
      DRAIN: begin
        commit_stall = 1'b1;
        flush        = 1'b1;
        if (!mem_busy) state_nx = WRITE;
      end
      WRITE: begin
        commit_stall = 1'b1;
        flush        = 1'b1;
        if (r_eret) begin
          cp0_clr_exl = 1'b1;
        end else begin
          cp0_exc_we   = 1'b1;
          cp0_epc_wd   = r_bd ? (r_pc - 32'd4) : r_pc;
          cp0_code_wd  = r_code;
          cp0_bd_wd    = r_bd;
          cp0_badva_we = r_badva_v;
          cp0_badva_wd = r_badva;
        end
        state_nx = REDIR;
      end
      REDIR: begin
        commit_stall   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = r_tgt;
        if (fetch_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_commit_seq.sv
// tb/tb_exc_commit_seq.sv - directed self-checking bench for exc_commit_seq
module tb_exc_commit_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s0_valid, s1_valid, s0_exc, s1_exc;
  logic [4:0]  s0_code, s1_code;
  logic [31:0] s0_pc, s1_pc, s0_badva, s1_badva;
  logic        s0_bd, s1_bd, s0_badva_v, s1_badva_v, s0_refill, s1_refill, s0_eret, s1_eret;
  logic        int_req, status_exl, mem_busy, fetch_ready;
  logic [31:0] cp0_epc;
  logic        commit_stall, s1_kill, flush, cp0_exc_we, cp0_bd_wd, cp0_badva_we, cp0_clr_exl;
  logic        redirect_valid;
  logic [31:0] cp0_epc_wd, cp0_badva_wd, redirect_pc;
  logic [4:0]  cp0_code_wd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  exc_commit_seq dut (
    .clk(clk), .resetn(resetn),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_exc(s0_exc), .s1_exc(s1_exc),
    .s0_code(s0_code), .s1_code(s1_code), .s0_pc(s0_pc), .s1_pc(s1_pc),
    .s0_bd(s0_bd), .s1_bd(s1_bd), .s0_badva_v(s0_badva_v), .s1_badva_v(s1_badva_v),
    .s0_badva(s0_badva), .s1_badva(s1_badva), .s0_refill(s0_refill), .s1_refill(s1_refill),
    .s0_eret(s0_eret), .s1_eret(s1_eret), .int_req(int_req), .status_exl(status_exl),
    .cp0_epc(cp0_epc), .mem_busy(mem_busy), .fetch_ready(fetch_ready),
    .commit_stall(commit_stall), .s1_kill(s1_kill), .flush(flush),
    .cp0_exc_we(cp0_exc_we), .cp0_epc_wd(cp0_epc_wd), .cp0_code_wd(cp0_code_wd),
    .cp0_bd_wd(cp0_bd_wd), .cp0_badva_we(cp0_badva_we), .cp0_badva_wd(cp0_badva_wd),
    .cp0_clr_exl(cp0_clr_exl), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slots();
    s0_valid = 0; s1_valid = 0; s0_exc = 0; s1_exc = 0; s0_code = 0; s1_code = 0;
    s0_pc = 0; s1_pc = 0; s0_bd = 0; s1_bd = 0; s0_badva_v = 0; s1_badva_v = 0;
    s0_badva = 0; s1_badva = 0; s0_refill = 0; s1_refill = 0; s0_eret = 0; s1_eret = 0;
    int_req = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, commit_stall}, 0);
    chk({tag, "_flush"}, {31'd0, flush}, 0);
    chk({tag, "_kill"}, {31'd0, s1_kill}, 0);
    chk({tag, "_excwe"}, {31'd0, cp0_exc_we}, 0);
    chk({tag, "_clrexl"}, {31'd0, cp0_clr_exl}, 0);
    chk({tag, "_rv"}, {31'd0, redirect_valid}, 0);
    chk({tag, "_rpc"}, redirect_pc, 0);
  endtask

  initial begin
    resetn = 0; status_exl = 0; mem_busy = 0; fetch_ready = 1; cp0_epc = 0;
    clear_slots();
    // Slot0 exception presented during reset must not leak through.
    s0_valid = 1; s0_exc = 1;
    tick(); tick();
    #1 chk_all_zero("reset");
    clear_slots();
    resetn = 1;
    #1 chk_all_zero("idle");

    // s0 exception, s1 present: kill s1, write next cycle, redirect the one after.
    s0_valid = 1; s0_exc = 1; s0_code = 5'h0A; s0_pc = 32'h80001000; s1_valid = 1;
    #1;
    chk("t1_stall", {31'd0, commit_stall}, 1);
    chk("t1_flush", {31'd0, flush}, 1);
    chk("t1_kill", {31'd0, s1_kill}, 1);
    chk("t1_excwe_early", {31'd0, cp0_exc_we}, 0);
    tick(); clear_slots(); #1;
    chk("t1_excwe", {31'd0, cp0_exc_we}, 1);
    chk("t1_epc", cp0_epc_wd, 32'h80001000);
    chk("t1_code", {27'd0, cp0_code_wd}, 32'h0A);
    chk("t1_bd", {31'd0, cp0_bd_wd}, 0);
    chk("t1_badvawe", {31'd0, cp0_badva_we}, 0);
    chk("t1_rv_early", {31'd0, redirect_valid}, 0);
    tick();
    chk("t1_rv", {31'd0, redirect_valid}, 1);
    chk("t1_rpc", redirect_pc, 32'hBFC00380);
    chk("t1_flush_redir", {31'd0, flush}, 0);
    chk("t1_stall_redir", {31'd0, commit_stall}, 1);
    tick();
    chk("t1_rv_drop", {31'd0, redirect_valid}, 0);
    chk("t1_stall_idle", {31'd0, commit_stall}, 0);

    // s0 clean, s1 AdEL in a delay slot with a BadVAddr.
    s0_valid = 1; s0_pc = 32'h80002000;
    s1_valid = 1; s1_exc = 1; s1_code = 5'h04; s1_pc = 32'h80002004; s1_bd = 1;
    s1_badva_v = 1; s1_badva = 32'h00000003;
    #1;
    chk("t2_kill", {31'd0, s1_kill}, 1);
    chk("t2_stall", {31'd0, commit_stall}, 1);
    tick(); clear_slots(); #1;
    chk("t2_excwe", {31'd0, cp0_exc_we}, 1);
    chk("t2_epc", cp0_epc_wd, 32'h80002000);
    chk("t2_code", {27'd0, cp0_code_wd}, 32'h04);
    chk("t2_bd", {31'd0, cp0_bd_wd}, 1);
    chk("t2_badvawe", {31'd0, cp0_badva_we}, 1);
    chk("t2_badva", cp0_badva_wd, 32'h00000003);
    tick();
    chk("t2_rpc", redirect_pc, 32'hBFC00380);
    tick();

    // TLB refill with EXL clear uses the refill vector.
    s0_valid = 1; s0_exc = 1; s0_code = 5'h02; s0_refill = 1; s0_pc = 32'h80004000;
    status_exl = 0;
    tick(); clear_slots(); status_exl = 1; tick();
    chk("t3_rv", {31'd0, redirect_valid}, 1);
    chk("t3_rpc_refill", redirect_pc, 32'hBFC00200);
    tick();
    // Same with EXL set uses the general vector.
    s0_valid = 1; s0_exc = 1; s0_code = 5'h02; s0_refill = 1; s0_pc = 32'h80004000;
    tick(); clear_slots(); status_exl = 0; tick();
    chk("t3_rpc_exl", redirect_pc, 32'hBFC00380);
    tick();

    // Outstanding bus transaction delays the CP0 write.
    s0_valid = 1; s0_exc = 1; s0_code = 5'h0C; s0_pc = 32'h80005000; mem_busy = 1;
    #1 chk("t4_flush_ev", {31'd0, flush}, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); clear_slots(); #1;
      chk($sformatf("t4_drain%0d_excwe", i), {31'd0, cp0_exc_we}, 0);
      chk($sformatf("t4_drain%0d_stall", i), {31'd0, commit_stall}, 1);
      chk($sformatf("t4_drain%0d_flush", i), {31'd0, flush}, 1);
    end
    mem_busy = 0;
    #1 chk("t4_excwe_fall", {31'd0, cp0_exc_we}, 0);
    tick();
    chk("t4_excwe", {31'd0, cp0_exc_we}, 1);
    chk("t4_epc", cp0_epc_wd, 32'h80005000);
    chk("t4_flush_wr", {31'd0, flush}, 1);
    tick(); tick();

    // ERET with fetch back-pressure; EPC changes after WRITE must not move the target.
    s0_valid = 1; s0_eret = 1; s0_pc = 32'h80006000; cp0_epc = 32'h80003000; fetch_ready = 0;
    tick(); clear_slots(); #1;
    chk("t5_clrexl", {31'd0, cp0_clr_exl}, 1);
    chk("t5_excwe", {31'd0, cp0_exc_we}, 0);
    tick();
    cp0_epc = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_hold%0d_rv", i), {31'd0, redirect_valid}, 1);
      chk($sformatf("t5_hold%0d_rpc", i), redirect_pc, 32'h80003000);
      chk($sformatf("t5_hold%0d_clr", i), {31'd0, cp0_clr_exl}, 0);
      tick();
    end
    fetch_ready = 1;
    #1 chk("t5_rv_last", {31'd0, redirect_valid}, 1);
    chk("t5_rpc_last", redirect_pc, 32'h80003000);
    tick();
    chk("t5_rv_drop", {31'd0, redirect_valid}, 0);

    // Reset in DRAIN aborts the sequence.
    s0_valid = 1; s0_exc = 1; s0_code = 5'h0A; s0_pc = 32'h80007000; mem_busy = 1;
    tick(); clear_slots(); #1;
    chk("t6_in_drain", {31'd0, commit_stall}, 1);
    resetn = 0;
    tick();
    chk_all_zero("t6_rst");
    resetn = 1; mem_busy = 0;
    #1 chk_all_zero("t6_after");
    tick();
    chk_all_zero("t6_nowrite");

    // Interrupt on slot0 yields code 0 and a normal sequence.
    s0_valid = 1; int_req = 1; s0_pc = 32'h80008000;
    #1 chk("t7_stall", {31'd0, commit_stall}, 1);
    tick(); clear_slots(); #1;
    chk("t7_excwe", {31'd0, cp0_exc_we}, 1);
    chk("t7_code", {27'd0, cp0_code_wd}, 0);
    chk("t7_epc", cp0_epc_wd, 32'h80008000);
    tick();
    chk("t7_rpc", redirect_pc, 32'hBFC00380);
    tick();

    // Interrupt attaches to slot1 when slot0 is empty, overriding its code.
    s1_valid = 1; int_req = 1; s1_exc = 1; s1_code = 5'h0A; s1_pc = 32'h80009008;
    tick(); clear_slots(); #1;
    chk("t8_code", {27'd0, cp0_code_wd}, 0);
    chk("t8_epc", cp0_epc_wd, 32'h80009008);
    tick(); tick();
    chk("t8_idle", {31'd0, commit_stall}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
